// File: rtl/pid_pkg.sv
// Shared types, widths and the saturation helper for the PID sequencer.
package pid_pkg;

   typedef enum logic [1:0] {IDLE, MUL_P, MUL_D, SUM} state_t;

   localparam int RAW_W  = 16;
   localparam int ERR_W  = 10;
   localparam int DIFF_W = 7;
   localparam int PID_W  = 12;
   localparam int INT_W  = 16;
   localparam int COEF_W = 6;
   localparam int PROD_W = 16;

   // Clips a signed value into the range representable in 'width' bits.
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                     input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/pid_shared_mult.sv
// Registered signed 10x6 multiply with one cycle of latency; the caller muxes the operands.
module pid_shared_mult
   import pid_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [ERR_W-1:0]  a,
   input  logic signed [COEF_W-1:0] b,
   output logic signed [PROD_W-1:0] prod
);

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
      end else if (en) begin
         prod <= PROD_W'(a) * PROD_W'(b);
      end
   end

endmodule

// File: rtl/pid_sched.sv
// PID sequencer: saturates error samples, time-shares one multiplier for P and D, sums P+I+D.
// Define PID_I_TERM_EN to build the integrator and add the I term into the sum.
module pid_sched
   import pid_pkg::*;
#(
   parameter logic signed [COEF_W-1:0] P_COEFF       = 6'sh03,
   parameter logic signed [COEF_W-1:0] D_COEFF       = 6'sh0B,
   parameter int                       D_QUEUE_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [RAW_W-1:0] error,
   input  logic                    err_in_vld,
   output logic                    err_rdy,
   input  logic                    clr_int,
   output logic signed [PID_W-1:0] pid,
   output logic                    pid_vld
);

   state_t                   state;
   logic signed [ERR_W-1:0]  err_sat_c;
   logic signed [ERR_W:0]    diff_c;
   logic signed [DIFF_W-1:0] diff_sat_c;
   logic signed [ERR_W-1:0]  err_q;
   logic signed [DIFF_W-1:0] diff_q;
   logic signed [ERR_W-1:0]  hist [D_QUEUE_DEPTH];
   logic signed [PROD_W-1:0] p_q;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] i_term;
   logic signed [PROD_W-1:0] sum_c;
   logic signed [ERR_W-1:0]  mult_a;
   logic signed [COEF_W-1:0] mult_b;
   logic                     mult_en;
   logic                     accept;

   assign err_rdy = (state == IDLE) && !clr_int;
   assign accept  = err_in_vld && err_rdy;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      err_sat_c  = ERR_W'(sat_signed(32'(error), ERR_W));
      diff_c     = (ERR_W + 1)'(err_sat_c) - (ERR_W + 1)'(hist[D_QUEUE_DEPTH-1]);
      diff_sat_c = DIFF_W'(sat_signed(32'(diff_c), DIFF_W));
      mult_en    = (state == MUL_P) || (state == MUL_D);
      mult_a     = err_q;
      mult_b     = P_COEFF;
      if (state == MUL_D) begin
         mult_a = ERR_W'(diff_q);
         mult_b = D_COEFF;
      end
   end

   pid_shared_mult u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mult_en),
      .a     (mult_a),
      .b     (mult_b),
      .prod  (prod)
   );

`ifdef PID_I_TERM_EN
   logic signed [INT_W-1:0] integ;
   logic signed [INT_W-1:0] integ_next;
   logic signed [INT_W-1:0] i_q;

   assign integ_next = INT_W'(sat_signed(32'(integ) + 32'(err_sat_c), INT_W));
   assign i_term     = i_q;

   // The I term is captured at accept so a later clear cannot disturb the sample in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ <= '0;
         i_q   <= '0;
      end else if (clr_int) begin
         integ <= '0;
      end else if (accept) begin
         integ <= integ_next;
         i_q   <= integ_next >>> 4;
      end
   end
`else
   assign i_term = '0;
`endif

   assign sum_c = p_q + i_term + prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         err_q   <= '0;
         diff_q  <= '0;
         p_q     <= '0;
         pid     <= '0;
         pid_vld <= 1'b0;
         // NOTE: the history array is reset explicitly because the first derivative depends on it.
         for (int i = 0; i < D_QUEUE_DEPTH; i++) hist[i] <= '0;
      end else begin
         pid_vld <= 1'b0;
         if (clr_int) begin
            for (int i = 0; i < D_QUEUE_DEPTH; i++) hist[i] <= '0;
         end else if (accept) begin
            err_q   <= err_sat_c;
            diff_q  <= diff_sat_c;
            hist[0] <= err_sat_c;
            for (int i = 1; i < D_QUEUE_DEPTH; i++) hist[i] <= hist[i-1];
         end
         case (state)
            IDLE:    if (accept) state <= MUL_P;
            MUL_P:   state <= MUL_D;
            MUL_D: begin
               p_q   <= prod;
               state <= SUM;
            end
            SUM: begin
               pid     <= PID_W'(sat_signed(32'(sum_c), PID_W));
               pid_vld <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
